mux_pipe: RTL and testbench
===========================

Name: mux_pipe

Overview:
- Parametrised N-input, WIDTH-bit selector for the datapath.
- A valid/ready-registered output stage backed by a 2-entry skid buffer.
- Used between execute/memory result sources and the writeback path so that selection is registered and pipeline stalls never drop or duplicate a word.
- Generalises the plain 2:1/4:1 selectors with arbitrary width and input count, backpressure, flush, and out-of-range select detection.

Parameters:
- WIDTH, 32, data width of each input and of dout.
- N, 4, number of inputs, 2..16.
- SEL_W, $clog2(N), width of sel.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled on acceptance.
- in_valid  in  1  upstream offers din/sel this cycle.
- in_ready  out  1  block can accept this cycle.
- out_valid  out  1  dout/sel_err hold a valid word.
- out_ready  in  1  downstream consumes the word this cycle.
- flush  in  1  synchronous discard of all buffered words.
- dout  out  WIDTH  selected word at head of buffer.
- sel_err  out  1  head word was captured with sel >= N.
- occupancy  out  2  number of buffered words, 0..2.

Behaviour:
- Reset (rst_n low, asynchronous): occupancy=0, out_valid=0, dout=0, sel_err=0, both buffer entries cleared to 0, in_ready=1 once rst_n is released.
- Accept (push) = in_valid & in_ready; consume (pop) = out_valid & out_ready.
- Pushed word = din[sel*WIDTH +: WIDTH] when sel < N; when sel >= N (only possible if N is not a power of 2) the pushed word is all zeros with err bit 1. Never X or Z.
- Latency: a word pushed at edge t is visible on dout/out_valid after edge t. There is no combinational path from din/sel to dout.
- in_ready = (occupancy < 2), derived from registered occupancy only; no combinational path from out_ready.
- Buffer is a 2-entry FIFO with head at dout. Next occupancy:
  - push & !pop → +1
  - pop & !push → -1
  - push & pop → unchanged, with the head replaced by the next entry or the new word in order.
- FIFO order is strict; words are never reordered, dropped or duplicated.
- out_valid = (occupancy != 0). While out_valid=1 and out_ready=0, dout and sel_err hold stable.
- At occupancy=2 in_ready=0. A simultaneous pop still frees one slot, but that slot is not offered until the next cycle.
- When occupancy=0, out_ready is ignored and dout holds its last value; out_valid=0 marks it as invalid.
- flush=1: next occupancy=0, out_valid=0, sel_err=0. Flush has priority over push and pop in the same cycle, so a word offered with flush=1 is discarded. dout value after flush is don't-care but stable.
- rst_n asserted mid-transfer: buffered words are lost and all outputs go to reset values immediately, without waiting for clk.
- sel_err travels with its word through the buffer and reflects only the current head.

Test Plan:
- Reset/idle: hold rst_n=0, then release; in_valid=0 → out_valid=0, dout=0, in_ready=1, occupancy=0.
- Select sweep, no stall: N=4, WIDTH=32, din={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=0,1,2,3 on consecutive cycles, out_ready=1 → dout=0xAAAA0000,0xBBBB0001,0xCCCC0002,0xDDDD0003 one cycle after each push, in_ready stays 1.
- Backpressure: out_ready=0, push 3 words A,B,C → A,B accepted, occupancy=2, in_ready=0, C held; raise out_ready → drains A then B, then C is accepted; output order is A,B,C with no loss or duplication.
- Simultaneous push/pop at occupancy=1 → occupancy stays 1 and dout advances to the next word in order.
- Out-of-range select: N=3, sel=3 → dout=0, sel_err=1 for that word only; the next push with sel=1 → sel_err=0.
- Flush: occupancy=2 and flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, in_ready=1, and the offered word is absent from the output. An async rst_n pulse mid-drain clears out_valid without waiting for a clock edge.

Source files
------------

// File: rtl/mux_pipe.sv
// N-input WIDTH-bit registered selector with a 2-entry skid buffer on the output.
// The head entry drives dout; sel_err flags words captured with an out-of-range select.
module mux_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   dout,
  output logic               sel_err,
  output logic [1:0]         occupancy
);

  logic [WIDTH-1:0] head_data, tail_data;
  logic             head_err, tail_err;
  logic [1:0]       occ_q;

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             push, pop;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sel_word = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = din[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (occ_q < 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: both buffer entries are reset explicitly; dout must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
      head_err  <= 1'b0;
      tail_err  <= 1'b0;
    end else if (flush) begin
      occ_q    <= 2'd0;
      head_err <= 1'b0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_data <= sel_word;
            head_err  <= sel_bad;
            occ_q     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= sel_word;
            head_err  <= sel_bad;
          end else if (push) begin
            tail_data <= sel_word;
            tail_err  <= sel_bad;
            occ_q     <= 2'd2;
          end else if (pop) begin
            occ_q <= 2'd0;
          end
        end
        2'd2: begin
          // Full: no push possible; a pop promotes the tail into the head slot.
          if (pop) begin
            head_data <= tail_data;
            head_err  <= tail_err;
            occ_q     <= 2'd1;
          end
        end
        default: occ_q <= 2'd0;
      endcase
    end
  end

  assign dout      = head_data;
  assign sel_err   = head_err & out_valid;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench: an N=4 and an N=3 instance share stimulus and are compared
// every cycle against a queue-based model of the selector FIFO.
module tb_mux_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din_w [4];
  logic [127:0] din4;
  logic [95:0]  din3;
  logic [1:0]  sel;
  logic        in_valid, out_ready, flush;

  logic        in_ready4, out_valid4, sel_err4;
  logic [31:0] dout4;
  logic [1:0]  occ4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [31:0] dout3;
  logic [1:0]  occ3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d4;
    logic [31:0] d3;
    logic        e3;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  assign din4 = {din_w[3], din_w[2], din_w[1], din_w[0]};
  assign din3 = din4[95:0];

  mux_pipe #(.WIDTH(32), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready),
    .flush(flush), .dout(dout4), .sel_err(sel_err4), .occupancy(occ4)
  );

  mux_pipe #(.WIDTH(32), .N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready),
    .flush(flush), .dout(dout3), .sel_err(sel_err3), .occupancy(occ3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two words; flush empties it, otherwise pop then push.
  task automatic model_update();
    entry_t e;
    int     s;
    bit     do_push, do_pop;
    if (flush) begin
      q.delete();
      return;
    end
    do_push = in_valid && (q.size() < 2);
    do_pop  = (q.size() != 0) && out_ready;
    s = int'(sel);
    e.d4 = din_w[s];
    e.d3 = (s < 3) ? din_w[s] : 32'h0;
    e.e3 = (s >= 3);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
  endtask

  task automatic compare();
    int sz;
    sz = q.size();
    check("occupancy4", 64'(occ4), 64'(sz));
    check("occupancy3", 64'(occ3), 64'(sz));
    check("out_valid4", 64'(out_valid4), 64'(sz != 0));
    check("out_valid3", 64'(out_valid3), 64'(sz != 0));
    check("in_ready4",  64'(in_ready4),  64'(sz < 2));
    check("in_ready3",  64'(in_ready3),  64'(sz < 2));
    check("sel_err4",   64'(sel_err4),   64'(0));
    check("sel_err3",   64'(sel_err3),   64'((sz != 0) ? q[0].e3 : 1'b0));
    if (sz != 0) begin
      check("dout4", 64'(dout4), 64'(q[0].d4));
      check("dout3", 64'(dout3), 64'(q[0].d3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  logic [31:0] sweep_exp [4];

  initial begin
    rst_n     = 1'b0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 4; i++) din_w[i] = 32'h0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid4), 64'(0));
    check("reset_dout",      64'(dout4),      64'(0));
    check("reset_in_ready",  64'(in_ready4),  64'(1));
    check("reset_occ",       64'(occ4),       64'(0));
    check("reset_sel_err3",  64'(sel_err3),   64'(0));
    compare();

    // Select sweep with no stall; dut3 sees sel=3 out of range on the last push
    din_w[0] = 32'hAAAA0000; din_w[1] = 32'hBBBB0001;
    din_w[2] = 32'hCCCC0002; din_w[3] = 32'hDDDD0003;
    sweep_exp[0] = 32'hAAAA0000; sweep_exp[1] = 32'hBBBB0001;
    sweep_exp[2] = 32'hCCCC0002; sweep_exp[3] = 32'hDDDD0003;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      check("sweep_dout", 64'(dout4), 64'(sweep_exp[i]));
      check("sweep_in_ready", 64'(in_ready4), 64'(1));
    end
    check("oob_dout3", 64'(dout3), 64'(0));
    check("oob_sel_err3", 64'(sel_err3), 64'(1));
    sel = 2'd1;
    step();
    check("inrange_sel_err3", 64'(sel_err3), 64'(0));
    check("inrange_dout3", 64'(dout3), 64'(32'hBBBB0001));
    in_valid = 1'b0;
    step();

    // Backpressure: A, B accepted, C held until a slot frees
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    din_w[0]  = 32'h0000000A; step();
    din_w[0]  = 32'h0000000B; step();
    din_w[0]  = 32'h0000000C; step();
    check("bp_occ_full", 64'(occ4), 64'(2));
    check("bp_in_ready", 64'(in_ready4), 64'(0));
    check("bp_hold_A", 64'(dout4), 64'(32'hA));
    step();
    check("bp_still_A", 64'(dout4), 64'(32'hA));
    out_ready = 1'b1;
    step();
    check("bp_drain_B", 64'(dout4), 64'(32'hB));
    check("bp_occ_1", 64'(occ4), 64'(1));
    step();
    check("pushpop_C", 64'(dout4), 64'(32'hC));
    check("pushpop_occ", 64'(occ4), 64'(1));
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid4), 64'(0));

    // Flush at full with a word offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din_w[0]  = 32'h11; step();
    din_w[0]  = 32'h22; step();
    din_w[0]  = 32'h33;
    flush     = 1'b1;
    step();
    check("flush_occ", 64'(occ4), 64'(0));
    check("flush_out_valid", 64'(out_valid4), 64'(0));
    check("flush_in_ready", 64'(in_ready4), 64'(1));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("flush_word_absent", 64'(out_valid4), 64'(0));

    // Asynchronous reset mid-drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din_w[0]  = 32'h44; step();
    din_w[0]  = 32'h55; step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid4), 64'(0));
    check("async_occ", 64'(occ4), 64'(0));
    check("async_dout", 64'(dout4), 64'(0));
    q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    compare();

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) din_w[i] = $urandom;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
